// File: rtl/i2c_reg_seq.sv
// rtl/i2c_reg_seq.sv - register read/write sequencer driving a byte-level I2C master
// Splits each request into master byte commands and handles NACK abort, arbitration loss and bus-busy retry.
module i2c_reg_seq #(
  parameter int MAX_RETRY = 3,
  parameter int RETRY_DLY = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [1:0] rsp_err,
  output logic [7:0] rsp_rdata,
  output logic [4:0] m_cmd,
  output logic       m_ws,
  output logic [7:0] m_dat,
  input  logic [6:0] m_stat,
  input  logic [7:0] m_dat_in,
  output logic       busy
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int DW = (RETRY_DLY < 2) ? 1 : $clog2(RETRY_DLY);

  localparam logic [4:0] C_STRT = 5'b00001;
  localparam logic [4:0] C_STOP = 5'b00010;
  localparam logic [4:0] C_READ = 5'b00100;
  localparam logic [4:0] C_WRTE = 5'b01000;
  localparam logic [4:0] C_NACK = 5'b10000;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ABORT, BACKOFF, RESP} state_t;

  state_t        state;
  logic [1:0]    step;
  logic [RW-1:0] retry;
  logic [DW-1:0] dly;
  logic          stop_sent;
  logic          rd_q;
  logic [6:0]    dev_q;
  logic [7:0]    reg_q;
  logic [7:0]    wdata_q;

  logic st_bsy, st_ack, st_bbl, st_alo, st_err, st_don;
  logic unused_bby;
  assign unused_bby = m_stat[6];
  assign st_bsy = m_stat[5];
  assign st_ack = m_stat[4];
  assign st_bbl = m_stat[3];
  assign st_alo = m_stat[2];
  assign st_err = m_stat[1];
  assign st_don = m_stat[0];

  assign req_ready = rst && (state == IDLE) && !st_bsy;

  logic [4:0] step_cmd;
  logic [7:0] step_dat;
  logic       last_step;

  always_comb begin
    step_cmd  = C_STRT | C_WRTE;
    step_dat  = {dev_q, 1'b0};
    last_step = rd_q ? (step == 2'd3) : (step == 2'd2);
    case (step)
      2'd1: begin
        step_cmd = C_WRTE;
        step_dat = reg_q;
      end
      2'd2: begin
        if (rd_q) begin
          step_cmd = C_STRT | C_WRTE;
          step_dat = {dev_q, 1'b1};
        end else begin
          step_cmd = C_WRTE | C_STOP;
          step_dat = wdata_q;
        end
      end
      2'd3: begin
        step_cmd = C_READ | C_NACK | C_STOP;
        step_dat = 8'h00;
      end
      default: ;
    endcase
  end

  // Status is only trusted once the strobe has dropped, so stale DON from the previous byte is never seen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      step      <= 2'd0;
      retry     <= '0;
      dly       <= '0;
      stop_sent <= 1'b0;
      rd_q      <= 1'b0;
      dev_q     <= 7'h00;
      reg_q     <= 8'h00;
      wdata_q   <= 8'h00;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 2'd0;
      rsp_rdata <= 8'h00;
      m_ws      <= 1'b0;
      m_cmd     <= 5'd0;
      m_dat     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            rd_q      <= req_rd;
            dev_q     <= req_dev;
            reg_q     <= req_reg;
            wdata_q   <= req_wdata;
            step      <= 2'd0;
            retry     <= '0;
            busy      <= 1'b1;
            rsp_err   <= 2'd0;
            rsp_rdata <= 8'h00;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!st_bsy) begin
            m_ws  <= 1'b1;
            m_cmd <= step_cmd;
            m_dat <= step_dat;
            state <= WAIT;
          end
        end
        WAIT: begin
          m_ws <= 1'b0;
          if (!m_ws && !st_bsy && st_don) begin
            if (st_err) begin
              if (st_alo) begin
                rsp_err   <= 2'd2;
                rsp_valid <= 1'b1;
                state     <= RESP;
              end else if (st_bbl && (retry < RW'(MAX_RETRY))) begin
                retry <= retry + RW'(1);
                step  <= 2'd0;
                dly   <= DW'(RETRY_DLY - 1);
                state <= BACKOFF;
              end else begin
                rsp_err   <= 2'd3;
                rsp_valid <= 1'b1;
                state     <= RESP;
              end
            end else if (m_cmd[3] && !st_ack) begin
              if (last_step) begin
                rsp_err   <= 2'd1;
                rsp_valid <= 1'b1;
                state     <= RESP;
              end else begin
                stop_sent <= 1'b0;
                state     <= ABORT;
              end
            end else if (last_step) begin
              if (rd_q) rsp_rdata <= m_dat_in;
              rsp_err   <= 2'd0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              step  <= step + 2'd1;
              state <= ISSUE;
            end
          end
        end
        ABORT: begin
          if (!stop_sent) begin
            if (!st_bsy) begin
              m_ws      <= 1'b1;
              m_cmd     <= C_STOP;
              m_dat     <= 8'h00;
              stop_sent <= 1'b1;
            end
          end else begin
            m_ws <= 1'b0;
            if (!m_ws && !st_bsy && st_don) begin
              rsp_err   <= 2'd1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        BACKOFF: begin
          if (dly == '0) state <= ISSUE;
          else dly <= dly - DW'(1);
        end
        RESP: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb/tb_i2c_reg_seq.sv - directed bench with behavioural I2C master and command/response scoreboard
// The master answers each strobe after a few busy cycles; slave behaviour is steered by bench knobs.
module tb_i2c_reg_seq;

  localparam int MAXR = 3;
  localparam int DLY  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_rd;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_wdata;
  logic       rsp_valid;
  logic [1:0] rsp_err;
  logic [7:0] rsp_rdata;
  logic [4:0] m_cmd;
  logic       m_ws;
  logic [7:0] m_dat;
  logic [6:0] m_stat = 7'b0100000;
  logic [7:0] m_dat_in = 8'h00;
  logic       busy;

  i2c_reg_seq #(.MAX_RETRY(MAXR), .RETRY_DLY(DLY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .m_cmd(m_cmd), .m_ws(m_ws), .m_dat(m_dat),
    .m_stat(m_stat), .m_dat_in(m_dat_in), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int ws_total = 0;
  int rsp_total = 0;
  logic [12:0] exp_bus[$];
  logic [9:0]  exp_rsp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave/bus knobs
  logic [6:0] absent_dev = 7'h22;
  logic [7:0] slave_data = 8'h00;
  bit         nack_final = 0;
  bit         alo_next = 0;
  bit         hold_forever = 0;
  int         hold_cnt = 0;

  int         init_cnt = 0;
  int         bcnt = 0;
  logic [4:0] cur_cmd = 5'd0;
  logic [7:0] cur_dat = 8'h00;
  logic       ack;

  always @(negedge clk) begin
    if (hold_cnt > 0) hold_cnt--;
    if (!rst) begin
      m_stat = 7'b0100000;
      init_cnt = 3;
      bcnt = 0;
    end else if (init_cnt > 0) begin
      init_cnt--;
      if (init_cnt == 0) m_stat = 7'b0000000;
    end else if (m_ws) begin
      cur_cmd = m_cmd;
      cur_dat = m_dat;
      m_stat = 7'b0100000;
      bcnt = 3;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) begin
        if (cur_cmd[0] && (hold_forever || hold_cnt > 0)) begin
          m_stat = 7'b0001011;
        end else if (cur_cmd[0] && alo_next) begin
          alo_next = 0;
          m_stat = 7'b0000111;
        end else if (cur_cmd[3]) begin
          ack = !((cur_cmd[0] && cur_dat[7:1] == absent_dev) || (cur_cmd[1] && nack_final));
          m_stat = {2'b00, ack, 4'b0001};
        end else if (cur_cmd[2]) begin
          m_dat_in = slave_data;
          m_stat = 7'b0000001;
        end else begin
          m_stat = 7'b0000001;
        end
      end
    end
  end

  logic prev_ws = 1'b0;
  logic [12:0] tok;
  logic [9:0]  rsp_exp;

  always @(negedge clk) begin
    if (m_ws) begin
      ws_total++;
      chk("ws_not_back_to_back", prev_ws, 1'b0);
      chk("cmd_not_clrs", (m_cmd != 5'd0), 1'b1);
      if (exp_bus.size() == 0) chk("unexpected_strobe", {m_cmd, m_dat}, 13'h1fff);
      else begin
        tok = exp_bus.pop_front();
        chk("bus_cmd_dat", {m_cmd, m_dat}, tok);
      end
    end
    if (rsp_valid) begin
      rsp_total++;
      if (exp_rsp.size() == 0) chk("unexpected_rsp", {rsp_err, rsp_rdata}, 10'h3ff);
      else begin
        rsp_exp = exp_rsp.pop_front();
        chk("rsp_err_rdata", {rsp_err, rsp_rdata}, rsp_exp);
      end
    end
    prev_ws = m_ws;
  end

  function automatic logic [12:0] t(input logic [4:0] c, input logic [7:0] d);
    return {c, d};
  endfunction

  task automatic txn(input string tag, input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                     input logic [7:0] wd, input int exp_ws, input logic [1:0] err, input logic [7:0] rdata);
    int ws0, rs0, k;
    k = 0;
    while (!req_ready && k < 200) begin @(negedge clk); k++; end
    chk({tag, "_ready"}, req_ready, 1'b1);
    exp_rsp.push_back({err, rdata});
    ws0 = ws_total;
    rs0 = rsp_total;
    req_valid = 1'b1; req_rd = rd; req_dev = dev; req_reg = rg; req_wdata = wd;
    @(negedge clk);
    chk({tag, "_busy"}, busy, 1'b1);
    req_valid = 1'b0;
    req_rd = 1'($urandom); req_dev = 7'($urandom); req_reg = 8'($urandom); req_wdata = 8'($urandom);
    k = 0;
    while (rsp_total == rs0 && k < 1000) begin @(negedge clk); k++; end
    chk({tag, "_rsp_count"}, rsp_total - rs0, 1);
    @(negedge clk);
    chk({tag, "_rsp_pulse"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_hold"}, {rsp_err, rsp_rdata}, {err, rdata});
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_ws_count"}, ws_total - ws0, exp_ws);
    chk({tag, "_bus_drained"}, exp_bus.size(), 0);
  endtask

  int ws0, rs0, k;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_rd = 1'b0; req_dev = 7'h00; req_reg = 8'h00; req_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {req_ready, busy, rsp_valid, rsp_err, rsp_rdata, m_ws, m_cmd, m_dat}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_waits_master_init", req_ready, 1'b0);

    exp_bus.push_back(t(5'b01001, 8'hA0)); exp_bus.push_back(t(5'b01000, 8'h10));
    exp_bus.push_back(t(5'b01010, 8'hA5));
    txn("write", 1'b0, 7'h50, 8'h10, 8'hA5, 3, 2'd0, 8'h00);

    slave_data = 8'h3C;
    exp_bus.push_back(t(5'b01001, 8'hA0)); exp_bus.push_back(t(5'b01000, 8'h02));
    exp_bus.push_back(t(5'b01001, 8'hA1)); exp_bus.push_back(t(5'b10110, 8'h00));
    txn("read", 1'b1, 7'h50, 8'h02, 8'h00, 4, 2'd0, 8'h3C);

    exp_bus.push_back(t(5'b01001, 8'h44)); exp_bus.push_back(t(5'b00010, 8'h00));
    txn("addr_nack", 1'b0, 7'h22, 8'h10, 8'h11, 2, 2'd1, 8'h00);

    nack_final = 1;
    exp_bus.push_back(t(5'b01001, 8'hA0)); exp_bus.push_back(t(5'b01000, 8'h20));
    exp_bus.push_back(t(5'b01010, 8'h77));
    txn("data_nack", 1'b0, 7'h50, 8'h20, 8'h77, 3, 2'd1, 8'h00);
    nack_final = 0;

    hold_cnt = (5 * DLY) / 2;
    repeat (3) exp_bus.push_back(t(5'b01001, 8'hA0));
    exp_bus.push_back(t(5'b01000, 8'h11)); exp_bus.push_back(t(5'b01010, 8'h5A));
    txn("bbl_retry", 1'b0, 7'h50, 8'h11, 8'h5A, 5, 2'd0, 8'h00);

    hold_forever = 1;
    repeat (MAXR + 1) exp_bus.push_back(t(5'b01001, 8'hA0));
    txn("bbl_giveup", 1'b0, 7'h50, 8'h12, 8'h34, MAXR + 1, 2'd3, 8'h00);
    hold_forever = 0;

    alo_next = 1;
    exp_bus.push_back(t(5'b01001, 8'hA0));
    txn("arb_lost", 1'b0, 7'h50, 8'h13, 8'h56, 1, 2'd2, 8'h00);

    exp_bus.push_back(t(5'b01001, 8'hA0)); exp_bus.push_back(t(5'b01000, 8'h30));
    ws0 = ws_total; rs0 = rsp_total;
    k = 0;
    while (!req_ready && k < 200) begin @(negedge clk); k++; end
    req_valid = 1'b1; req_rd = 1'b0; req_dev = 7'h50; req_reg = 8'h30; req_wdata = 8'h99;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (ws_total < ws0 + 2 && k < 200) begin @(negedge clk); k++; end
    chk("mid_reset_reached_step1", ws_total - ws0, 2);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs", {req_ready, busy, rsp_valid, rsp_err, rsp_rdata, m_ws, m_cmd, m_dat}, 0);
    @(negedge clk);
    exp_bus.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_ready_after_init", req_ready, 1'b0);
    repeat (10) @(negedge clk);
    chk("mid_reset_no_rsp", rsp_total - rs0, 0);
    chk("mid_reset_no_more_strobes", ws_total - ws0, 2);

    exp_bus.push_back(t(5'b01001, 8'hFE)); exp_bus.push_back(t(5'b01000, 8'hFF));
    exp_bus.push_back(t(5'b01010, 8'h00));
    txn("recover_write", 1'b0, 7'h7F, 8'hFF, 8'h00, 3, 2'd0, 8'h00);

    chk("rsp_queue_drained", exp_rsp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
